// File: rtl/pulse_meter_if.sv
// Result channel of pulse_meter: measured interval plus valid/ready handshake
// and the sticky overrun flag. WIDTH must match the attached pulse_meter.
interface pulse_meter_if #(
    parameter int WIDTH = 16
) ();
    logic             meas_ready;
    logic             meas_valid;
    logic [WIDTH-1:0] meas_width;
    logic             meas_level;
    logic             meas_ovf;
    logic             overrun;

    modport master (
        input  meas_ready,
        output meas_valid,
        output meas_width,
        output meas_level,
        output meas_ovf,
        output overrun
    );

    modport slave (
        output meas_ready,
        input  meas_valid,
        input  meas_width,
        input  meas_level,
        input  meas_ovf,
        input  overrun
    );
endinterface

// File: rtl/pulse_meter.sv
// Measures the length, in clk cycles, of each completed high/low interval of an
// asynchronous level and hands the result out over a valid/ready channel.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | not measuring; waiting for an edge while enabled
// MEASURE | counting the current interval; the next edge closes it
module pulse_meter #(
    parameter int WIDTH = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_sig,
    input  logic          enable,
    pulse_meter_if.master meas
);
    typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic             s1, s2, s3;
    logic             edge_det;
    state_t           state, state_next;
    logic [WIDTH-1:0] cnt, cnt_next;
    logic             sat, sat_next;
    logic             load;
    logic [WIDTH-1:0] res_width;
    logic             res_ovf;
    logic             accept;
    logic             drop;

    // Synchronize the async input; s3 holds the previous settled level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= in_sig;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det = s2 ^ s3;

    // FSM state, interval counter and saturation flag registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            sat   <= sat_next;
        end
    end

    // Next state, counter update and result generation on a closing edge.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sat_next   = sat;
        load       = 1'b0;
        res_width  = '0;
        res_ovf    = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                sat_next = 1'b0;
                if (edge_det && enable) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (edge_det) begin
                    // cnt == CNT_MAX means cnt+1 would wrap, so the interval overflowed.
                    load      = 1'b1;
                    res_ovf   = sat || (cnt == CNT_MAX);
                    res_width = res_ovf ? CNT_MAX : cnt + WIDTH'(1);
                    cnt_next  = '0;
                    sat_next  = 1'b0;
                end else if (cnt == CNT_MAX) begin
                    sat_next = 1'b1;
                end else begin
                    cnt_next = cnt + WIDTH'(1);
                end
                // A closing edge in the same cycle still yields its result above.
                if (!enable) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    sat_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                sat_next   = 1'b0;
            end
        endcase
    end

    assign accept = meas.meas_valid && meas.meas_ready;
    assign drop   = load && meas.meas_valid && !meas.meas_ready;

    // Result holding register with handshake and sticky overrun.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meas.meas_valid <= 1'b0;
            meas.meas_width <= '0;
            meas.meas_level <= 1'b0;
            meas.meas_ovf   <= 1'b0;
            meas.overrun    <= 1'b0;
        end else begin
            if (load && !drop) begin
                meas.meas_valid <= 1'b1;
                meas.meas_width <= res_width;
                meas.meas_level <= s3;
                meas.meas_ovf   <= res_ovf;
            end else if (accept) begin
                meas.meas_valid <= 1'b0;
            end
            if (drop) begin
                meas.overrun <= 1'b1;
            end else if (accept) begin
                meas.overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: two instances (WIDTH=16 and WIDTH=4) share stimulus.
// A run-length model predicts every result; directed phases pin the model.
module tb_pulse_meter;
    logic clock = 1'b0;
    logic reset;
    logic in_sig;
    logic enable;
    logic ready;

    pulse_meter_if #(.WIDTH(16)) bus16 ();
    pulse_meter_if #(.WIDTH(4))  bus4 ();

    assign bus16.meas_ready = ready;
    assign bus4.meas_ready  = ready;

    pulse_meter #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(reset), .in_sig(in_sig), .enable(enable), .meas(bus16)
    );
    pulse_meter #(.WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .in_sig(in_sig), .enable(enable), .meas(bus4)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int n;
        bit lvl;
    } res_t;

    res_t res_log[$];
    bit   hist[$];
    int   c;
    bit   armed;
    int   run_start;
    bit   m_valid;
    bit   m_lvl;
    int   m_n;
    bit   m_ovr;
    bit   ed, lvl_old, acc, newres, drp;
    int   n_new;

    // in_sig as sampled k posedges ago (k=1 is the current posedge); 0 before reset release
    function automatic bit past(int k);
        if (hist.size() >= k) return hist[hist.size() - k];
        return 1'b0;
    endfunction

    function automatic longint ew(int n, int mx);
        return (n > mx) ? mx : n;
    endfunction

    function automatic int log_n(int i);
        if (i < res_log.size()) return res_log[i].n;
        return -1;
    endfunction

    function automatic int log_l(int i);
        if (i < res_log.size()) return int'(res_log[i].lvl);
        return -1;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist.delete();
            c = 0; armed = 0; run_start = 0;
            m_valid = 0; m_lvl = 0; m_n = 0; m_ovr = 0;
        end else begin
            c++;
            hist.push_back(in_sig);
            if (hist.size() > 8) void'(hist.pop_front());
            // a level change becomes visible two samples late and is acted on one later
            ed      = past(3) != past(4);
            lvl_old = past(4);
            acc     = m_valid && ready;
            newres  = ed && armed;
            n_new   = c - run_start;
            drp     = newres && m_valid && !ready;
            if (newres) res_log.push_back('{n_new, lvl_old});
            if (newres && !drp) begin
                m_valid = 1; m_n = n_new; m_lvl = lvl_old;
            end else if (acc) begin
                m_valid = 0;
            end
            if (drp) m_ovr = 1;
            else if (acc) m_ovr = 0;
            if (ed) begin
                armed = enable; run_start = c;
            end else if (!enable) begin
                armed = 0;
            end
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge clock) begin
        chk("valid16",   bus16.meas_valid, m_valid);
        chk("valid4",    bus4.meas_valid,  m_valid);
        chk("level16",   bus16.meas_level, m_lvl);
        chk("level4",    bus4.meas_level,  m_lvl);
        chk("width16",   bus16.meas_width, ew(m_n, 65535));
        chk("width4",    bus4.meas_width,  ew(m_n, 15));
        chk("ovf16",     bus16.meas_ovf,   m_n > 65535);
        chk("ovf4",      bus4.meas_ovf,    m_n > 15);
        chk("overrun16", bus16.overrun,    m_ovr);
        chk("overrun4",  bus4.overrun,     m_ovr);
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 0; in_sig = 0; enable = 0; ready = 0;
        repeat (3) @(negedge clock);
        reset = 1;
        repeat (2) @(negedge clock);
        chk("rst_valid", bus16.meas_valid, 0);
        chk("rst_width", bus16.meas_width, 0);
        chk("rst_overrun", bus16.overrun, 0);

        // basic measurement: 20 high, 12 low
        enable = 1; ready = 1;
        repeat (3) @(negedge clock);
        in_sig = 1;
        repeat (20) @(negedge clock);
        res_log.delete();
        in_sig = 0;
        @(posedge clock); #1 chk("lat_k_valid", bus16.meas_valid, 0);
        @(posedge clock); #1 chk("lat_k1_valid", bus16.meas_valid, 0);
        @(posedge clock); #1;
        chk("lat_k2_valid", bus16.meas_valid, 1);
        chk("basic_width20", bus16.meas_width, 20);
        chk("basic_level1", bus16.meas_level, 1);
        @(negedge clock);
        repeat (9) @(negedge clock);
        in_sig = 1;
        repeat (6) @(negedge clock);
        chk("basic_count", res_log.size(), 2);
        chk("basic_log_w0", log_n(0), 20);
        chk("basic_log_l0", log_l(0), 1);
        chk("basic_log_w1", log_n(1), 12);
        chk("basic_log_l1", log_l(1), 0);

        // backpressure: 5, 7, 9 with ready low
        in_sig = 0;
        repeat (4) @(negedge clock);
        ready = 0;
        @(negedge clock); in_sig = 1;
        repeat (7) @(negedge clock); in_sig = 0;
        repeat (9) @(negedge clock); in_sig = 1;
        repeat (5) @(negedge clock);
        chk("bp_valid", bus16.meas_valid, 1);
        chk("bp_width5", bus16.meas_width, 5);
        chk("bp_level0", bus16.meas_level, 0);
        chk("bp_overrun", bus16.overrun, 1);
        ready = 1;
        @(posedge clock); #1;
        chk("bp_acc_valid", bus16.meas_valid, 0);
        chk("bp_acc_overrun", bus16.overrun, 0);

        // back-to-back 1-cycle intervals with simultaneous accept
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i >= 4) begin
                chk("b2b_valid", bus16.meas_valid, 1);
                chk("b2b_width1", bus16.meas_width, 1);
                chk("b2b_overrun", bus16.overrun, 0);
            end
            in_sig = ~in_sig;
        end

        // saturation: 20 high then 3 low
        @(negedge clock); in_sig = 0;
        repeat (6) @(negedge clock);
        in_sig = 1;
        repeat (20) @(negedge clock);
        in_sig = 0;
        repeat (3) @(negedge clock);
        chk("sat_w4", bus4.meas_width, 15);
        chk("sat_ovf4", bus4.meas_ovf, 1);
        chk("sat_w16", bus16.meas_width, 20);
        chk("sat_ovf16", bus16.meas_ovf, 0);
        in_sig = 1;
        repeat (3) @(negedge clock);
        chk("after_sat_w4", bus4.meas_width, 3);
        chk("after_sat_ovf4", bus4.meas_ovf, 0);

        // enable drop inside a high interval
        repeat (4) @(negedge clock); in_sig = 0;
        repeat (4) @(negedge clock); in_sig = 1;
        repeat (10) @(negedge clock);
        res_log.delete();
        enable = 0;
        repeat (5) @(negedge clock); enable = 1;
        repeat (5) @(negedge clock); in_sig = 0;
        repeat (4) @(negedge clock);
        chk("en_first_edge_nores", bus16.meas_valid, 0);
        repeat (2) @(negedge clock); in_sig = 1;
        repeat (4) @(negedge clock);
        chk("en_count", res_log.size(), 1);
        chk("en_log_w", log_n(0), 6);
        chk("en_log_l", log_l(0), 0);

        // async reset mid-count with a held result
        ready = 0;
        repeat (2) @(negedge clock); in_sig = 0;
        repeat (5) @(negedge clock);
        chk("pre_rst_valid", bus16.meas_valid, 1);
        chk("pre_rst_level", bus16.meas_level, 1);
        repeat (3) @(negedge clock);
        #3 reset = 0;
        #1;
        chk("arst_valid16", bus16.meas_valid, 0);
        chk("arst_width16", bus16.meas_width, 0);
        chk("arst_level16", bus16.meas_level, 0);
        chk("arst_ovf16", bus16.meas_ovf, 0);
        chk("arst_overrun16", bus16.overrun, 0);
        chk("arst_valid4", bus4.meas_valid, 0);
        chk("arst_width4", bus4.meas_width, 0);
        in_sig = 1;
        @(negedge clock);
        @(negedge clock);
        reset = 1;
        res_log.delete();
        ready = 1;
        repeat (8) @(negedge clock);
        chk("post_rst_nores", res_log.size(), 0);
        chk("post_rst_valid", bus16.meas_valid, 0);
        in_sig = 0;
        repeat (5) @(negedge clock);
        chk("post_rst_count", res_log.size(), 1);
        chk("post_rst_w", log_n(0), 8);
        chk("post_rst_l", log_l(0), 1);

        // randomized intervals, backpressure and enable glitches
        for (int cyc = 0; cyc < 2500; ) begin
            int len;
            if ($urandom_range(0, 3) == 0) len = $urandom_range(14, 17);
            else len = $urandom_range(1, 40);
            in_sig = ~in_sig;
            for (int j = 0; j < len; j++) begin
                @(negedge clock);
                ready  = ($urandom_range(0, 9) < 7);
                enable = ($urandom_range(0, 79) != 0);
                cyc++;
            end
        end
        enable = 1; ready = 1;
        repeat (6) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
